// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared width, latency-counter width and FSM encodings for the data-memory responder
package dmem_responder_pkg;

    localparam int WIDTH     = 64;
    localparam int LAT_CNT_W = 3;

    localparam logic [1:0] DMEM_IDLE = 2'd0;
    localparam logic [1:0] DMEM_WAIT = 2'd1;
    localparam logic [1:0] DMEM_RESP = 2'd2;

endpackage

// File: rtl/dmem_responder_bank.sv
// rtl/dmem_responder_bank.sv - single-port word array with byte-lane write enables and registered read
module dmem_responder_bank
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               sys_clk,
    input  logic               en,
    input  logic               we,
    input  logic [IDX_W-1:0]   idx,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wmask,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // rdata only moves on a read, so it stays stable while a response is held
    always_ff @(posedge sys_clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < WIDTH / 8; i++) begin
                    if (wmask[i]) begin
                        mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-modelling data-memory responder; `define DMEM_RANGE_CHECK_EN enables address range errors
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DATA_W  = WIDTH,
    parameter int          DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [63:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wmask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [1:0]           state;
    logic [LAT_CNT_W-1:0] cnt;
    logic                 lat_write;
    logic [63:0]          lat_addr;
    logic [DATA_W-1:0]    lat_wdata;
    logic [DATA_W/8-1:0]  lat_wmask;
    logic                 rsp_err_q;

    logic                 accept;
    logic                 commit;
    logic                 range_err;
    logic [63:0]          offset;
    logic [IDX_W-1:0]     idx;
    logic [DATA_W-1:0]    bank_rdata;
    logic                 unused_offset_bits;

    assign req_ready = (state == DMEM_IDLE) && !sys_rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == DMEM_RESP);

    // Subtracting BASE makes addresses below BASE wrap high, so one compare covers both ends
    assign offset = lat_addr - BASE;
    assign idx    = offset[IDX_W+2:3];
    assign unused_offset_bits = ^{offset[2:0], offset[63:IDX_W+3]};

`ifdef DMEM_RANGE_CHECK_EN
    assign range_err = (offset >= (64'(DEPTH) * 64'd8));
`else
    assign range_err = 1'b0;
`endif

    // The bank samples on the edge that moves WAIT -> RESP; a reset on that edge cancels it
    assign commit = (state == DMEM_WAIT) && (cnt == '0) && !sys_rst;

    dmem_responder_bank #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .sys_clk (sys_clk),
        .en      (commit && !range_err),
        .we      (lat_write),
        .idx     (idx),
        .wdata   (lat_wdata),
        .wmask   (lat_wmask),
        .rdata   (bank_rdata)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= DMEM_IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    if (accept) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wmask <= req_wmask;
                        cnt       <= LAT_CNT_W'(LATENCY - 1);
                        state     <= DMEM_WAIT;
                    end
                end
                DMEM_WAIT: begin
                    if (cnt == '0) begin
                        rsp_err_q <= range_err;
                        state     <= DMEM_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DMEM_RESP: begin
                    if (rsp_ready) begin
                        rsp_err_q <= 1'b0;
                        state     <= DMEM_IDLE;
                    end
                end
                default: state <= DMEM_IDLE;
            endcase
        end
    end

    // Stores and errored loads return zero; loads show the bank's registered word
    assign rsp_rdata = (rsp_valid && !lat_write && !rsp_err_q) ? bank_rdata : '0;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int passed = 0;
    int total  = 0;

    dmem_responder #(
        .DATA_W  (64),
        .DEPTH   (4096),
        .BASE    (64'h8000_0000),
        .LATENCY (2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [7:0] wm, output int lat, output logic [63:0] rd,
                          output logic er);
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = wm;
        req_valid = 1'b1;
        lat = 0;
        while (!req_ready && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = ~addr;
        req_wdata = ~wd;
        req_wmask = ~wm;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        tick();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else passed++;
        total++; if (rsp_rdata !== 64'h0) $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); else passed++;
        total++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); else passed++;
        sys_rst = 1'b0;
        tick();
        total++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready got=%b exp=1", req_ready); else passed++;
    endtask

    task automatic test_store_load();
        int lat; logic [63:0] rd; logic er;
        do_req(1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, lat, rd, er);
        total++; if (lat !== 2) $display("FAIL store_latency got=%0d exp=2", lat); else passed++;
        total++; if (rd !== 64'h0) $display("FAIL store_rdata got=%h exp=0", rd); else passed++;
        total++; if (er !== 1'b0) $display("FAIL store_err got=%b exp=0", er); else passed++;
        do_req(1'b0, 64'h8000_0010, 64'h0, 8'h00, lat, rd, er);
        total++; if (lat !== 2) $display("FAIL load_latency got=%0d exp=2", lat); else passed++;
        total++; if (rd !== 64'h1122334455667788) $display("FAIL load_rdata got=%h exp=1122334455667788", rd); else passed++;
    endtask

    task automatic test_partial_store();
        int lat; logic [63:0] rd; logic er;
        do_req(1'b1, 64'h8000_0010, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, lat, rd, er);
        do_req(1'b0, 64'h8000_0017, 64'h0, 8'h00, lat, rd, er);
        total++; if (rd !== 64'h11223344_BBBBBBBB) $display("FAIL partial_rdata got=%h exp=11223344bbbbbbbb", rd); else passed++;
        do_req(1'b1, 64'h8000_0010, 64'hFFFFFFFF_FFFFFFFF, 8'h00, lat, rd, er);
        total++; if (lat !== 2) $display("FAIL zero_mask_latency got=%0d exp=2", lat); else passed++;
        do_req(1'b0, 64'h8000_0010, 64'h0, 8'h00, lat, rd, er);
        total++; if (rd !== 64'h11223344_BBBBBBBB) $display("FAIL zero_mask_rdata got=%h exp=11223344bbbbbbbb", rd); else passed++;
        do_req(1'b1, 64'h8000_0010, 64'h99000000_00000000, 8'h80, lat, rd, er);
        do_req(1'b0, 64'h8000_0010, 64'h0, 8'h00, lat, rd, er);
        total++; if (rd !== 64'h99223344_BBBBBBBB) $display("FAIL top_lane_rdata got=%h exp=99223344bbbbbbbb", rd); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] rd; logic er;
        do_req(1'b1, 64'h8000_0030, 64'h0F0E0D0C0B0A0908, 8'hFF, lat, rd, er);
        do_req(1'b0, 64'h8000_0030, 64'h0, 8'h00, lat, rd, er);
        total++; if (rd !== 64'h0F0E0D0C0B0A0908) $display("FAIL raw_rdata got=%h exp=0f0e0d0c0b0a0908", rd); else passed++;
        total++; if (lat !== 2) $display("FAIL raw_latency got=%0d exp=2", lat); else passed++;
    endtask

    task automatic test_backpressure();
        int lat; logic [63:0] rd; logic er;
        rsp_ready = 1'b0;
        req_write = 1'b0;
        req_addr  = 64'h8000_0010;
        req_valid = 1'b1;
        tick();
        req_write = 1'b1;
        req_addr  = 64'h8000_0040;
        req_wdata = 64'h5555666677778888;
        req_wmask = 8'hFF;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        total++; if (lat !== 2) $display("FAIL bp_latency got=%0d exp=2", lat); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (rsp_valid !== 1'b1) $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, rsp_valid); else passed++;
            total++; if (rsp_rdata !== 64'h99223344_BBBBBBBB) $display("FAIL bp_hold_rdata cyc=%0d got=%h exp=99223344bbbbbbbb", i, rsp_rdata); else passed++;
            total++; if (req_ready !== 1'b0) $display("FAIL bp_hold_req_ready cyc=%0d got=%b exp=0", i, req_ready); else passed++;
        end
        rsp_ready = 1'b1;
        tick();
        total++; if (rsp_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", rsp_valid); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL bp_release_req_ready got=%b exp=1", req_ready); else passed++;
        tick();
        req_valid = 1'b0;
        total++; if (req_ready !== 1'b0) $display("FAIL bp_accept_req_ready got=%b exp=0", req_ready); else passed++;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        total++; if (lat !== 2) $display("FAIL bp_second_latency got=%0d exp=2", lat); else passed++;
        total++; if (rsp_rdata !== 64'h0) $display("FAIL bp_second_rdata got=%h exp=0", rsp_rdata); else passed++;
        tick();
        do_req(1'b0, 64'h8000_0040, 64'h0, 8'h00, lat, rd, er);
        total++; if (rd !== 64'h5555666677778888) $display("FAIL bp_store_landed got=%h exp=5555666677778888", rd); else passed++;
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] rd; logic er;
        do_req(1'b1, 64'h8000_0020, 64'h0102030405060708, 8'hFF, lat, rd, er);
        req_write = 1'b1;
        req_addr  = 64'h8000_0020;
        req_wdata = 64'hDEADBEEFDEADBEEF;
        req_wmask = 8'hFF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        sys_rst = 1'b1;
        tick();
        total++; if (rsp_valid !== 1'b0) $display("FAIL midrst_valid_in_reset got=%b exp=0", rsp_valid); else passed++;
        sys_rst = 1'b0;
        tick();
        tick();
        total++; if (rsp_valid !== 1'b0) $display("FAIL midrst_valid_after got=%b exp=0", rsp_valid); else passed++;
        do_req(1'b0, 64'h8000_0020, 64'h0, 8'h00, lat, rd, er);
        total++; if (rd !== 64'h0102030405060708) $display("FAIL midrst_word got=%h exp=0102030405060708", rd); else passed++;
    endtask

    task automatic test_out_of_range();
        int lat; logic [63:0] rd; logic er;
        do_req(1'b1, 64'h8000_7FF8, 64'hCAFEF00D12345678, 8'hFF, lat, rd, er);
        do_req(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, lat, rd, er);
        total++; if (lat !== 2) $display("FAIL oor_latency got=%0d exp=2", lat); else passed++;
`ifdef DMEM_RANGE_CHECK_EN
        total++; if (er !== 1'b1) $display("FAIL oor_err got=%b exp=1", er); else passed++;
        total++; if (rd !== 64'h0) $display("FAIL oor_rdata got=%h exp=0", rd); else passed++;
        do_req(1'b0, 64'h8000_8000, 64'h0, 8'h00, lat, rd, er);
        total++; if (er !== 1'b1) $display("FAIL oor_top_err got=%b exp=1", er); else passed++;
        do_req(1'b0, 64'h8000_7FF8, 64'h0, 8'h00, lat, rd, er);
        total++; if (er !== 1'b0) $display("FAIL inrange_last_err got=%b exp=0", er); else passed++;
`else
        total++; if (er !== 1'b0) $display("FAIL wrap_err got=%b exp=0", er); else passed++;
        total++; if (rd !== 64'hCAFEF00D12345678) $display("FAIL wrap_rdata got=%h exp=cafef00d12345678", rd); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_partial_store();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_out_of_range();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
